icache_data_ram_nway: RTL and testbench
=======================================

Name: icache_data_ram_nway

Overview:
- N-way set-associative instruction-cache data array with a built-in line-refill sequencer.
- Sits beside the icache tag array inside the icache top.
- Serves one-cycle-latency fetch reads from a selected way.
- Assembles memory refill beats into a full line and writes each beat into the chosen way.
- Successor to the single-way, whole-line-write data RAM: adds ways, beat-granular fill with handshake, read/fill arbitration, and optional parity.

Parameters:
- NUM_WAYS, 2, number of ways; one bank per way.
- NUM_COL, 4, columns per line.
- COL_WIDTH, 32, bits per column.
- NUM_SETS, ICACHE_NO_OF_SETS, sets per way.
- FILL_WIDTH, 32, bits per refill beat; must divide NUM_COL*COL_WIDTH and be a multiple of COL_WIDTH.
- DATA_WIDTH, NUM_COL*COL_WIDTH, line width (derived).
- ADDR_WIDTH, $clog2(NUM_SETS), set index width (derived).
- BEATS, DATA_WIDTH/FILL_WIDTH, beats per line (derived).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- rd_req  in  1  fetch read request.
- rd_ready  out  1  read accepted this cycle when rd_req=1.
- rd_addr  in  ADDR_WIDTH  set index of read.
- rd_way_oh  in  NUM_WAYS  one-hot way select, sampled with rd_req.
- rdata  out  DATA_WIDTH  read line.
- rvalid  out  1  rdata valid pulse.
- rd_perr  out  1  parity error on rdata; qualifies rvalid.
- fill_start  in  1  begin line refill.
- fill_addr  in  ADDR_WIDTH  set index of refill, sampled with fill_start.
- fill_way  in  $clog2(NUM_WAYS)  victim way, sampled with fill_start.
- fill_valid  in  1  refill beat present.
- fill_ready  out  1  beat accepted when fill_valid=1.
- fill_data  in  FILL_WIDTH  refill beat, lowest beat first.
- fill_done  out  1  one-cycle pulse after last beat written.
- fill_busy  out  1  high while state is FILL.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, beat_cnt=0.
  - rvalid=0, rdata=0, rd_perr=0, fill_done=0.
  - Array contents are not reset.
  - Reset mid-fill abandons the fill; that line's contents become undefined. The tag side must keep it invalid.
- FSM IDLE:
  - rd_ready=1, fill_ready=0, fill_busy=0.
  - fill_start=1 latches fill_addr/fill_way, clears beat_cnt and goes to FILL.
- FSM FILL:
  - rd_ready=0, fill_ready=1, fill_busy=1; fill_start is ignored.
  - Each fill_valid&&fill_ready writes fill_data into columns [beat_cnt*FILL_WIDTH +: FILL_WIDTH] of latched way/set; beat_cnt increments.
  - On beat BEATS-1: beat_cnt wraps to 0, state returns to IDLE, and fill_done pulses in the next cycle.
- fill_valid=0 in FILL: hold state; no timeout.
- Read:
  - Accepted read (rd_req&&rd_ready) at cycle N gives rdata/rvalid at N+1.
  - rdata is the AND-OR of all banks gated by rd_way_oh. Zero one-hot gives all zeros; multi-hot gives the OR of the selected ways.
  - Non-accepted cycles: rvalid=0 and rdata holds its previous value.
- rd_req and fill_start in the same IDLE cycle: the read is accepted and returns pre-fill data; the fill starts.
- Read issued the cycle fill_done pulses (state IDLE) returns the completed line; all beat writes have landed.
- Banks are read-first. A bank is never read and written in the same cycle, because reads are blocked in FILL.

Optional Feature:
- Macro ICACHE_DATA_PARITY_EN.
- Defined:
  - Each bank stores one even-parity bit per COL_WIDTH column, computed on beat write.
  - On read, parity is recomputed for the selected way(s).
  - rd_perr=1 with rvalid if any column mismatches.
  - Zero-one-hot reads report rd_perr=0.
- Undefined:
  - No parity storage.
  - rd_perr is held 0; the port is always present.

Decomposition:
- Package icache_data_pkg (imports cache_defs) holds:
  - fill state typedef enum {FILL_IDLE, FILL_ACTIVE};
  - default NUM_WAYS and FILL_WIDTH constants;
  - a parity-function helper.
- Sub-module icache_data_bank: single-port, one way, per-column write enable, registered read, optional parity bits. Instantiated NUM_WAYS times via generate.
- FSM, beat counter and way mux live in the top.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with rd_req=1 → rvalid=0, rdata=0, fill_busy=0, rd_ready=1 after release.
- Full fill then read: fill set 5, way 1, 4 beats 0x11111111..0x44444444 with gaps on fill_valid → fill_done exactly one cycle after beat 4. Then read set 5, way_oh=2'b10 → rdata=0x44444444_33333333_22222222_11111111 one cycle later.
- Read blocking: rd_req held during FILL → rd_ready=0 throughout; accepted the cycle after the last beat, returns the new line.
- Simultaneous rd_req and fill_start on set 7 way 0 (previous data 0xA5…) → read returns 0xA5…; the later read returns the filled data.
- Way isolation: fill set 3 way 0 with 0xAAAA…, way 1 with 0x5555… → rd_way_oh=01/10/00 return AAAA…/5555…/0.
- Reset mid-fill after beat 2 → state IDLE, beat_cnt 0, fill_busy=0; a new fill completes normally. With ICACHE_DATA_PARITY_EN, force-flip a stored bit → rd_perr=1 alongside rvalid.

Source files
------------

// File: rtl/icache_data_pkg.sv
// Shared types, default sizes and the column-parity helper for the icache data array.
package icache_data_pkg;

  localparam int ICACHE_NO_OF_SETS = 64;
  localparam int DEF_NUM_WAYS      = 2;
  localparam int DEF_FILL_WIDTH    = 32;
  localparam int PAR_MAX_WIDTH     = 256;

  typedef enum logic {FILL_IDLE, FILL_ACTIVE} fill_state_e;

  // Even parity of a column; callers zero-extend narrower columns.
  function automatic logic even_parity(input logic [PAR_MAX_WIDTH-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/icache_data_bank.sv
// One way of the icache data array: single port, per-column write enable, registered read.
// Optional per-column parity storage under ICACHE_DATA_PARITY_EN.
module icache_data_bank
  import icache_data_pkg::*;
#(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 32,
  parameter int NUM_SETS   = ICACHE_NO_OF_SETS,
  parameter int ADDR_WIDTH = $clog2(NUM_SETS),
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [NUM_COL-1:0]    col_we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
`ifdef ICACHE_DATA_PARITY_EN
  output logic [NUM_COL-1:0]    rpar,
`endif
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_SETS];

  // NOTE: the storage array has no reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_COL; c++) begin
      if (col_we[c]) mem[addr][c*COL_WIDTH +: COL_WIDTH] <= wdata[c*COL_WIDTH +: COL_WIDTH];
    end
  end

  // Read register updates only on reads, so the output holds between them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

`ifdef ICACHE_DATA_PARITY_EN
  logic [NUM_COL-1:0] par_mem [NUM_SETS];

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_COL; c++) begin
      if (col_we[c])
        par_mem[addr][c] <= even_parity(PAR_MAX_WIDTH'(wdata[c*COL_WIDTH +: COL_WIDTH]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpar <= '0;
    end else if (rd_en) begin
      rpar <= par_mem[addr];
    end
  end
`endif

endmodule

// File: rtl/icache_data_ram_nway.sv
// N-way icache data array with beat-granular refill sequencer and one-hot way read mux.
// Parity checking is enabled by defining ICACHE_DATA_PARITY_EN.
module icache_data_ram_nway
  import icache_data_pkg::*;
#(
  parameter int NUM_WAYS   = DEF_NUM_WAYS,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 32,
  parameter int NUM_SETS   = ICACHE_NO_OF_SETS,
  parameter int FILL_WIDTH = DEF_FILL_WIDTH,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int ADDR_WIDTH = $clog2(NUM_SETS),
  parameter int BEATS      = DATA_WIDTH / FILL_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_req,
  output logic                        rd_ready,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  input  logic [NUM_WAYS-1:0]         rd_way_oh,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        rvalid,
  output logic                        rd_perr,
  input  logic                        fill_start,
  input  logic [ADDR_WIDTH-1:0]       fill_addr,
  input  logic [$clog2(NUM_WAYS)-1:0] fill_way,
  input  logic                        fill_valid,
  output logic                        fill_ready,
  input  logic [FILL_WIDTH-1:0]       fill_data,
  output logic                        fill_done,
  output logic                        fill_busy
);

  localparam int COLS_PER_BEAT = FILL_WIDTH / COL_WIDTH;
  localparam int BCW           = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAY_W         = $clog2(NUM_WAYS);

  fill_state_e           state;
  logic [BCW-1:0]        beat_cnt;
  logic [ADDR_WIDTH-1:0] fill_addr_q;
  logic [WAY_W-1:0]      fill_way_q;
  logic [NUM_WAYS-1:0]   way_oh_q;
  logic                  rd_acc;
  logic                  beat_acc;
  logic                  last_beat;
  logic [NUM_COL-1:0]    beat_mask;
  logic [ADDR_WIDTH-1:0] bank_addr;
  logic [DATA_WIDTH-1:0] bank_wdata;
  logic [NUM_WAYS-1:0][DATA_WIDTH-1:0] bank_rdata;
  logic [DATA_WIDTH-1:0] rdata_mux;

  assign rd_ready   = (state == FILL_IDLE);
  assign fill_ready = (state == FILL_ACTIVE);
  assign fill_busy  = (state == FILL_ACTIVE);
  assign rd_acc     = rd_req && rd_ready;
  assign beat_acc   = fill_valid && fill_ready;
  assign last_beat  = (beat_cnt == BCW'(BEATS - 1));
  assign beat_mask  = NUM_COL'({COLS_PER_BEAT{1'b1}}) << (32'(beat_cnt) * COLS_PER_BEAT);
  assign bank_addr  = fill_busy ? fill_addr_q : rd_addr;
  assign bank_wdata = {BEATS{fill_data}};

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL_IDLE;
      beat_cnt  <= '0;
      fill_done <= 1'b0;
      rvalid    <= 1'b0;
      way_oh_q  <= '0;
    end else begin
      fill_done <= 1'b0;
      rvalid    <= rd_acc;
      if (rd_acc) way_oh_q <= rd_way_oh;
      case (state)
        FILL_IDLE: begin
          if (fill_start) begin
            beat_cnt <= '0;
            state    <= FILL_ACTIVE;
          end
        end
        FILL_ACTIVE: begin
          if (beat_acc) begin
            if (last_beat) begin
              beat_cnt  <= '0;
              state     <= FILL_IDLE;
              fill_done <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + BCW'(1);
            end
          end
        end
        default: state <= FILL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL_IDLE && fill_start) begin
      fill_addr_q <= fill_addr;
      fill_way_q  <= fill_way;
    end
  end

`ifdef ICACHE_DATA_PARITY_EN
  logic [NUM_WAYS-1:0][NUM_COL-1:0] bank_rpar;
`endif

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_bank
    icache_data_bank #(
      .NUM_COL   (NUM_COL),
      .COL_WIDTH (COL_WIDTH),
      .NUM_SETS  (NUM_SETS),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .rd_en (rd_acc && rd_way_oh[w]),
      .col_we((beat_acc && fill_way_q == WAY_W'(w)) ? beat_mask : '0),
      .addr  (bank_addr),
      .wdata (bank_wdata),
`ifdef ICACHE_DATA_PARITY_EN
      .rpar  (bank_rpar[w]),
`endif
      .rdata (bank_rdata[w])
    );
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    rdata_mux = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_oh_q[w]) rdata_mux = rdata_mux | bank_rdata[w];
    end
  end
  assign rdata = rdata_mux;

`ifdef ICACHE_DATA_PARITY_EN
  logic perr_any;
  always_comb begin
    perr_any = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      for (int c = 0; c < NUM_COL; c++) begin
        if (way_oh_q[w] &&
            (even_parity(PAR_MAX_WIDTH'(bank_rdata[w][c*COL_WIDTH +: COL_WIDTH])) != bank_rpar[w][c]))
          perr_any = 1'b1;
      end
    end
  end
  assign rd_perr = rvalid && perr_any;
`else
  assign rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_icache_data_ram_nway.sv
// Scoreboard bench for icache_data_ram_nway: reads push expected lines, rvalid pops and compares.
module tb_icache_data_ram_nway;

  localparam int AW = 6;
  localparam int DW = 128;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic [NW-1:0] rd_way_oh;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rd_perr;
  logic          fill_start;
  logic [AW-1:0] fill_addr;
  logic          fill_way;
  logic          fill_valid;
  logic          fill_ready;
  logic [31:0]   fill_data;
  logic          fill_done;
  logic          fill_busy;

  always #5 clk = ~clk;

  icache_data_ram_nway dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rd_way_oh (rd_way_oh),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rd_perr   (rd_perr),
    .fill_start(fill_start),
    .fill_addr (fill_addr),
    .fill_way  (fill_way),
    .fill_valid(fill_valid),
    .fill_ready(fill_ready),
    .fill_data (fill_data),
    .fill_done (fill_done),
    .fill_busy (fill_busy)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          perr;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [NW][8];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int set, input logic [NW-1:0] oh);
    logic [DW-1:0] r;
    r = '0;
    for (int w = 0; w < NW; w++) if (oh[w]) r = r | model[w][set];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int set, input logic [NW-1:0] oh, input logic perr);
    rd_req    = 1'b1;
    rd_addr   = AW'(set);
    rd_way_oh = oh;
    @(negedge clk);
    check("rd_ready_idle", rd_ready, 1);
    sb.push_back(exp_t'{model_read(set, oh), perr});
    tick();
    rd_req = 1'b0;
  endtask

  task automatic start_fill(input int set, input int way, input bit with_read);
    fill_start = 1'b1;
    fill_addr  = AW'(set);
    fill_way   = way[0];
    if (with_read) begin
      rd_req    = 1'b1;
      rd_addr   = AW'(set);
      rd_way_oh = NW'(1 << way);
    end
    @(negedge clk);
    check("start_idle_busy", fill_busy, 0);
    if (with_read) begin
      check("start_rd_ready", rd_ready, 1);
      sb.push_back(exp_t'{model_read(set, NW'(1 << way)), 1'b0});
    end
    tick();
    fill_start = 1'b0;
    rd_req     = 1'b0;
  endtask

  task automatic send_beats(input int set, input int way, input logic [DW-1:0] line,
                            input logic [3:0] gap_mask, input bit hold_rd);
    if (hold_rd) begin
      rd_req    = 1'b1;
      rd_addr   = AW'(set);
      rd_way_oh = NW'(1 << way);
    end
    for (int b = 0; b < 4; b++) begin
      if (gap_mask[b]) begin
        fill_valid = 1'b0;
        @(negedge clk);
        check("gap_busy", fill_busy, 1);
        if (hold_rd) check("gap_rd_blocked", rd_ready, 0);
        tick();
      end
      fill_valid = 1'b1;
      fill_data  = line[b*32 +: 32];
      @(negedge clk);
      check("beat_fill_ready", fill_ready, 1);
      check("beat_no_done", fill_done, 0);
      if (hold_rd) check("beat_rd_blocked", rd_ready, 0);
      tick();
    end
    fill_valid = 1'b0;
    model[way][set] = line;
    @(negedge clk);
    check("fill_done_pulse", fill_done, 1);
    check("fill_busy_clear", fill_busy, 0);
    if (hold_rd) begin
      check("rd_ready_after_fill", rd_ready, 1);
      sb.push_back(exp_t'{model_read(set, NW'(1 << way)), 1'b0});
    end
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    check("fill_done_single", fill_done, 0);
    tick();
  endtask

  // Output side of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rvalid) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", DW'(rvalid), '0);
      end else begin
        e = sb.pop_front();
        check("rdata", rdata, e.data);
        check("rd_perr", DW'(rd_perr), DW'(e.perr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    rd_req     = 1'b1;
    rd_addr    = '0;
    rd_way_oh  = 2'b01;
    fill_start = 1'b0;
    fill_addr  = '0;
    fill_way   = 1'b0;
    fill_valid = 1'b0;
    fill_data  = '0;

    // Reset with a read request pending.
    repeat (3) tick();
    rst_n  = 1'b1;
    rd_req = 1'b0;
    @(negedge clk);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, '0);
    check("rst_fill_busy", fill_busy, 0);
    check("rst_rd_ready", rd_ready, 1);
    check("rst_fill_done", fill_done, 0);
    check("rst_rd_perr", rd_perr, 0);
    tick();

    // Full fill with gaps, then read back.
    start_fill(5, 1, 1'b0);
    send_beats(5, 1, 128'h44444444_33333333_22222222_11111111, 4'b1010, 1'b0);
    do_read(5, 2'b10, 1'b0);
    tick();
    check("line5_literal", model_read(5, 2'b10), 128'h44444444_33333333_22222222_11111111);

    // Read held during fill: blocked, then returns the new line.
    start_fill(6, 0, 1'b0);
    send_beats(6, 0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 4'b0100, 1'b1);
    tick();

    // Simultaneous read and fill_start: read sees pre-fill data.
    start_fill(7, 0, 1'b0);
    send_beats(7, 0, {4{32'hA5A5A5A5}}, 4'b0000, 1'b0);
    start_fill(7, 0, 1'b1);
    send_beats(7, 0, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 4'b0001, 1'b0);
    do_read(7, 2'b01, 1'b0);
    tick();

    // Way isolation on set 3.
    start_fill(3, 0, 1'b0);
    send_beats(3, 0, {4{32'hAAAAAAAA}}, 4'b0000, 1'b0);
    start_fill(3, 1, 1'b0);
    send_beats(3, 1, {4{32'h55555555}}, 4'b0000, 1'b0);
    do_read(3, 2'b01, 1'b0);
    do_read(3, 2'b10, 1'b0);
    do_read(3, 2'b00, 1'b0);
    do_read(3, 2'b11, 1'b0);
    tick();

    // Reset after two beats abandons the fill; a new fill then completes.
    start_fill(2, 1, 1'b0);
    for (int b = 0; b < 2; b++) begin
      fill_valid = 1'b1;
      fill_data  = 32'h77770000 + b;
      tick();
    end
    fill_valid = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", fill_busy, 0);
    check("midrst_rd_ready", rd_ready, 1);
    check("midrst_fill_ready", fill_ready, 0);
    check("midrst_done", fill_done, 0);
    tick();
    start_fill(2, 1, 1'b0);
    send_beats(2, 1, 128'h13579BDF_2468ACE0_FEDCBA98_76543210, 4'b0010, 1'b0);
    do_read(2, 2'b10, 1'b0);
    tick();

`ifdef ICACHE_DATA_PARITY_EN
    // Corrupt one stored data bit: read must flag a parity error.
    dut.g_bank[1].u_bank.mem[5][0] = ~dut.g_bank[1].u_bank.mem[5][0];
    model[1][5][0] = ~model[1][5][0];
    do_read(5, 2'b10, 1'b1);
    do_read(5, 2'b00, 1'b0);
    tick();
`endif

    repeat (3) tick();
    check("sb_drain", DW'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
